i2c_bus_arbiter: RTL and testbench

- Shares the single board I2C master controller (24-bit {slave, sub-addr, data} write-command interface) between NREQ independent requesters: HDMI transmitter init, audio codec setup, runtime scaler/HDR register writer.
- Round-robin grant per transaction. Drives the controller's START/END/ACK handshake and returns per-requester done/error status.
- A watchdog prevents a hung bus from starving the other requesters.

---
 rtl/i2c_arb_pkg.sv | 29 ++
 rtl/i2c_bus_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 32 +++
 rtl/i2c_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter: FSM state encoding,
// the 24-bit {slave, sub-addr, data} command layout and retry timing.
package i2c_arb_pkg;

  localparam int I2C_CMD_W     = 24;
  localparam int RETRY_MAX     = 2;
  localparam int RETRY_GAP_CYC = 256;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_HIGH,
    DONE,
    RETRY_GAP
  } arb_state_t;

  typedef struct packed {
    logic [7:0] slave;
    logic [7:0] sub;
    logic [7:0] data;
  } i2c_cmd_t;

  // Index width for a requester vector; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester and controller-side signals of the I2C bus arbiter.
// master: the arbiter's view; slave: the requesters/controller view.
interface i2c_bus_arbiter_if #(
  parameter int NREQ = 3
);
  import i2c_arb_pkg::*;

  logic [NREQ-1:0]           req;
  logic [I2C_CMD_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]           done;
  logic [NREQ-1:0]           err;
  logic                      busy;
  logic [I2C_CMD_W-1:0]      ctl_data;
  logic                      ctl_start;
  logic                      ctl_end;
  logic                      ctl_ack;

  modport master (
    input  req, req_data, ctl_end, ctl_ack,
    output done, err, busy, ctl_data, ctl_start
  );

  modport slave (
    output req, req_data, ctl_end, ctl_ack,
    input  done, err, busy, ctl_data, ctl_start
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// strictly after the pointer (wrapping), as a one-hot grant and an index.
// Generic enough to be reused by other shared-resource arbiters.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from ptr+1 around to ptr itself, keep the first hit
  always_comb begin
    logic [IDX_W-1:0] pos;
    pos = '0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % NREQ);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master controller between NREQ requesters with a
// round-robin grant per transaction, a START/END/ACK handshake sequencer and
// a saturating watchdog that turns a hung bus into an error completion.
// Optional: define I2C_BUS_ARB_RETRY_EN to reissue a NACKed command up to
// RETRY_MAX more times, separated by RETRY_GAP_CYC idle cycles.
// TIMEOUT_CYC must be representable in CNT_W bits.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = 32768,
  parameter int CNT_W       = 16
) (
  input logic                iCLK,
  input logic                iRST_N,
  i2c_bus_arbiter_if.master  bus
);

  localparam int               IDX_W   = idx_width(NREQ);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] rr;
  logic [NREQ-1:0]  gnt_oh;
  logic [NREQ-1:0]  done_q;
  logic [NREQ-1:0]  err_q;
  logic             busy_q;
  logic             start_q;
  i2c_cmd_t         cmd_q;
  logic [CNT_W-1:0] wdog;

  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  i2c_cmd_t         pick_cmd;
  logic             active;
  logic             wd_hit;

`ifdef I2C_BUS_ARB_RETRY_EN
  logic [7:0]       gap_cnt;
  logic [1:0]       attempt;
`endif

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (bus.req),
    .ptr (rr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Select the command word belonging to the requester rr_pick chose
  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_cmd = bus.req_data[i*I2C_CMD_W +: I2C_CMD_W];
    end
  end

  assign active = (state == START) || (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign wd_hit = active && (wdog >= WD_LAST);

  // Transaction sequencer: grant, START/END handshake, watchdog, completion status
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr      <= IDX_W'(NREQ - 1);
      gnt_oh  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      cmd_q   <= '0;
      wdog    <= '0;
`ifdef I2C_BUS_ARB_RETRY_EN
      gap_cnt <= '0;
      attempt <= '0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= '0;
      if (wd_hit) begin
        // Hung bus: abandon the transfer and report an error to the owner
        start_q <= 1'b0;
        done_q  <= gnt_oh;
        err_q   <= gnt_oh;
        state   <= DONE;
      end else begin
        if (active) wdog <= wdog + CNT_W'(1);
        case (state)
          IDLE: begin
            if (pick_any) begin
              gnt_idx <= pick_idx;
              gnt_oh  <= pick_oh;
              cmd_q   <= pick_cmd;
              busy_q  <= 1'b1;
              start_q <= 1'b1;
              wdog    <= '0;
`ifdef I2C_BUS_ARB_RETRY_EN
              attempt <= '0;
`endif
              state   <= START;
            end
          end
          START: begin
            if (!bus.ctl_end) state <= WAIT_LOW;
          end
          WAIT_LOW: begin
            start_q <= 1'b0;
            state   <= WAIT_HIGH;
          end
          WAIT_HIGH: begin
            if (bus.ctl_end) begin
`ifdef I2C_BUS_ARB_RETRY_EN
              if (bus.ctl_ack && (attempt < 2'(RETRY_MAX))) begin
                attempt <= attempt + 2'd1;
                gap_cnt <= '0;
                state   <= RETRY_GAP;
              end else
`endif
              begin
                done_q <= gnt_oh;
                err_q  <= bus.ctl_ack ? gnt_oh : '0;
                state  <= DONE;
              end
            end
          end
          DONE: begin
            rr     <= gnt_idx;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
`ifdef I2C_BUS_ARB_RETRY_EN
          RETRY_GAP: begin
            if (gap_cnt == 8'(RETRY_GAP_CYC - 1)) begin
              start_q <= 1'b1;
              wdog    <= '0;
              state   <= START;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.ctl_start = start_q;
  assign bus.ctl_data  = cmd_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: stimulus pushes expected completions,
// a monitor pops and compares on every done pulse, and a behavioural
// controller model answers the START/END/ACK handshake.
module tb_i2c_bus_arbiter;

  localparam int NREQ        = 3;
  localparam int TIMEOUT_CYC = 32768;

  typedef struct {
    int          idx;
    bit          err;
    logic [23:0] cmd;
    bit          to;
  } exp_t;

  logic iCLK   = 1'b0;
  logic iRST_N = 1'b0;

  i2c_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_bus_arbiter #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (16)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  exp_t        sb[$];
  int          checks       = 0;
  int          failures     = 0;
  int          cyc          = 0;
  int          start_cyc    = 0;
  int          end_rise_cyc = -100000;
  int          n_starts     = 0;
  int          min_gap      = 1000000;
  int          xfer_len     = 5;
  bit          hang         = 1'b0;
  logic [23:0] nack_cmd     = 24'hFFFFFF;
  logic [23:0] last_cmd     = 24'h0;

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic push(input int idx, input bit err, input logic [23:0] cmd, input bit to);
    exp_t e;
    e.idx = idx; e.err = err; e.cmd = cmd; e.to = to;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k;
    k = 0;
    while (sb.size() != 0 && k < max_cyc) begin
      @(negedge iCLK);
      k++;
    end
    chk({name, "_drained"}, 32'(sb.size() == 0), 32'd1);
    bus.req = '0;
    sb.delete();
    repeat (3) @(negedge iCLK);
    chk({name, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_wait_high(input string name, output bit ok);
    int k;
    k  = 0;
    ok = 1'b0;
    while (k < 100 && !ok) begin
      @(negedge iCLK);
      k++;
      if (bus.busy && !bus.ctl_start) ok = 1'b1;
    end
    chk({name, "_reached_wait_high"}, 32'(ok), 32'd1);
  endtask

  // Controller model: answers each START by dropping END, holding, then raising it
  initial begin : ctl_model
    bus.ctl_end = 1'b1;
    bus.ctl_ack = 1'b0;
    forever begin
      @(negedge iCLK);
      if (bus.ctl_start) begin
        last_cmd  = bus.ctl_data;
        start_cyc = cyc;
        n_starts++;
        if (cyc - end_rise_cyc < min_gap) min_gap = cyc - end_rise_cyc;
        @(negedge iCLK);
        bus.ctl_end = 1'b0;
        bus.ctl_ack = 1'b0;
        if (hang) begin
          for (int k = 0; k < 40000 && bus.busy; k++) @(negedge iCLK);
          hang = 1'b0;
        end else begin
          repeat (xfer_len) @(negedge iCLK);
        end
        bus.ctl_end  = 1'b1;
        bus.ctl_ack  = (last_cmd == nack_cmd);
        end_rise_cyc = cyc;
      end
    end
  end

  // Monitor: scoreboard compare on each done pulse, plus ctl_data stability
  initial begin : monitor
    exp_t        e;
    bit          prev_start;
    logic [23:0] prev_data;
    logic [31:0] oh;
    prev_start = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge iCLK);
      if (!iRST_N) begin
        prev_start = 1'b0;
      end else begin
        if (bus.ctl_start && prev_start) chk("ctl_data_stable", 32'(bus.ctl_data), 32'(prev_data));
        prev_start = bus.ctl_start;
        prev_data  = bus.ctl_data;
        if (bus.done != '0) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(bus.done), 32'd0);
          end else begin
            e  = sb.pop_front();
            oh = 32'd1 << e.idx;
            chk("done_onehot", 32'(bus.done), oh);
            chk("err_value", 32'(bus.err), e.err ? oh : 32'd0);
            chk("ctl_data_frozen", 32'(bus.ctl_data), 32'(e.cmd));
            chk("cmd_issued", 32'(last_cmd), 32'(e.cmd));
            if (e.to) begin
              chk("timeout_cycles", 32'(cyc - start_cyc), 32'(TIMEOUT_CYC));
              chk("timeout_start_low", 32'(bus.ctl_start), 32'd0);
            end else begin
              chk("end_to_done_latency", 32'(cyc - end_rise_cyc), 32'd1);
            end
          end
        end else if (bus.err != '0) begin
          chk("err_without_done", 32'(bus.err), 32'd0);
        end
      end
    end
  end

  // Safety net so the run always terminates
  initial begin : global_guard
    #5_000_000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "global timeout");
  end

  // Directed stimulus sequence
  initial begin : stimulus
    bit ok;
    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(negedge iCLK);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ctl_start", 32'(bus.ctl_start), 32'd0);
    chk("rst_ctl_data", 32'(bus.ctl_data), 32'd0);
    iRST_N = 1'b1;
    @(negedge iCLK);

    // Single request, 100-cycle transfer, ACK
    bus.req_data[23:0] = 24'h724110;
    xfer_len = 100;
    push(0, 1'b0, 24'h724110, 1'b0);
    bus.req[0] = 1'b1;
    @(negedge iCLK);
    chk("start_latency", 32'(bus.ctl_start), 32'd1);
    chk("busy_on_grant", 32'(bus.busy), 32'd1);
    wait_drain("single", 400);

    // Contention from reset: all three held, strict round robin 0,1,2,0,1,2
    iRST_N = 1'b0;
    xfer_len = 5;
    bus.req_data = {24'h983003, 24'h720102, 24'h724110};
    bus.req = 3'b111;
    for (int r = 0; r < 2; r++) begin
      push(0, 1'b0, 24'h724110, 1'b0);
      push(1, 1'b0, 24'h720102, 1'b0);
      push(2, 1'b0, 24'h983003, 1'b0);
    end
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    wait_drain("round_robin", 400);

    // NACK on requester 1
    nack_cmd = 24'h72AF16;
    bus.req_data[47:24] = 24'h72AF16;
    n_starts = 0;
    min_gap  = 1000000;
    push(1, 1'b1, 24'h72AF16, 1'b0);
    bus.req[1] = 1'b1;
    wait_drain("nack", 2000);
`ifdef I2C_BUS_ARB_RETRY_EN
    chk("nack_attempts", 32'(n_starts), 32'd3);
    chk("nack_retry_gap_ok", 32'(min_gap >= 256), 32'd1);
`else
    chk("nack_attempts", 32'(n_starts), 32'd1);
`endif
    nack_cmd = 24'hFFFFFF;

    // Timeout on requester 0, requester 1 served afterwards
    hang = 1'b1;
    bus.req_data[23:0]  = 24'h7200AA;
    bus.req_data[47:24] = 24'h7201BB;
    push(0, 1'b1, 24'h7200AA, 1'b1);
    push(1, 1'b0, 24'h7201BB, 1'b0);
    bus.req = 3'b011;
    wait_drain("timeout", 34000);

    // Data freeze: requester changes its command during WAIT_HIGH
    xfer_len = 100;
    bus.req_data[23:0] = 24'h724110;
    push(0, 1'b0, 24'h724110, 1'b0);
    bus.req[0] = 1'b1;
    wait_wait_high("freeze", ok);
    repeat (5) @(negedge iCLK);
    bus.req_data[23:0] = 24'h721762;
    wait_drain("freeze", 400);

    // Asynchronous reset during WAIT_HIGH: no done, priority back to requester 0
    xfer_len = 200;
    bus.req_data[23:0] = 24'h724110;
    bus.req[0] = 1'b1;
    wait_wait_high("midrst", ok);
    repeat (10) @(negedge iCLK);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_ctl_start", 32'(bus.ctl_start), 32'd0);
    chk("midrst_ctl_data", 32'(bus.ctl_data), 32'd0);
    bus.req = '0;
    repeat (250) @(negedge iCLK);
    iRST_N = 1'b1;
    xfer_len = 5;
    bus.req_data[47:24] = 24'h720102;
    push(0, 1'b0, 24'h724110, 1'b0);
    push(1, 1'b0, 24'h720102, 1'b0);
    bus.req = 3'b011;
    wait_drain("post_reset", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
